// File: rtl/mul_share_if.sv
// Request/result bundle between the two issue lanes, the shared multiplier
// and writeback.
interface mul_share_if #(
  parameter int WIDTH = 4,
  parameter int TAG_W = 5
);
  // A transfer happens on the rising edge where valid & ready are both 1; the
  // producer holds valid and its payload stable until then, and ready never
  // waits on the same side's valid being low.
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [TAG_W-1:0] req1_tag;
  logic             flush;
  logic             res_valid;
  logic             res_ready;
  logic             res_lane;
  logic [TAG_W-1:0] res_tag;
  logic [WIDTH-1:0] res_p;
  logic             busy;
  logic             rr_dbg;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_a, req1_b, req1_tag,
    input  flush, res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_lane, res_tag, res_p, busy, rr_dbg
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_tag,
    output req1_valid, req1_a, req1_b, req1_tag,
    output flush, res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_lane, res_tag, res_p, busy, rr_dbg
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// One truncating multiplier shared by two issue lanes: round-robin grant,
// LAT-stage result pipe with whole-pipe stall on writeback backpressure.
module mul_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int TAG_W = 5,
  parameter int LAT   = 2
) (
  input logic      clk,
  input logic      rst,
  mul_share_if.slave bus
);

  logic                        stall;
  logic                        can_issue;
  logic                        grant0;
  logic                        grant1;
  logic [WIDTH-1:0]            sel_a;
  logic [WIDTH-1:0]            sel_b;
  logic [WIDTH-1:0]            sel_p;
  logic [TAG_W-1:0]            sel_tag;
  logic                        rr;
  logic                        rr_next;
  logic [LAT-1:0]              st_valid;
  logic [LAT-1:0]              st_lane;
  logic [LAT-1:0][TAG_W-1:0]   st_tag;
  logic [LAT-1:0][WIDTH-1:0]   st_p;

  // rr names the lane that wins when both lanes request together.
  always_comb begin
    stall     = st_valid[LAT-1] & ~bus.res_ready;
    can_issue = ~stall & ~bus.flush & ~rst;
    grant0    = can_issue & bus.req0_valid & (~bus.req1_valid | ~rr);
    grant1    = can_issue & bus.req1_valid & (~bus.req0_valid |  rr);
    sel_a     = grant1 ? bus.req1_a   : bus.req0_a;
    sel_b     = grant1 ? bus.req1_b   : bus.req0_b;
    sel_tag   = grant1 ? bus.req1_tag : bus.req0_tag;
    sel_p     = sel_a * sel_b;
    rr_next   = rr;
    if (grant0)      rr_next = 1'b1;
    else if (grant1) rr_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) rr <= 1'b0;
    else     rr <= rr_next;
  end

  // Flush only kills valid bits; payload of a dead stage is never observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid <= '0;
      st_lane  <= '0;
      st_tag   <= '0;
      st_p     <= '0;
    end else if (bus.flush) begin
      st_valid <= '0;
    end else if (!stall) begin
      st_valid[0] <= grant0 | grant1;
      st_lane[0]  <= grant1;
      st_tag[0]   <= sel_tag;
      st_p[0]     <= sel_p;
      for (int i = 1; i < LAT; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_lane[i]  <= st_lane[i-1];
        st_tag[i]   <= st_tag[i-1];
        st_p[i]     <= st_p[i-1];
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.res_valid  = st_valid[LAT-1];
  assign bus.res_lane   = st_lane[LAT-1];
  assign bus.res_tag    = st_tag[LAT-1];
  assign bus.res_p      = st_p[LAT-1];
  assign bus.busy       = |st_valid;
  assign bus.rr_dbg     = rr;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed scenarios plus random traffic, all
// results checked by a scoreboard fed from observed request handshakes.
module tb_mul_share_arbiter;
  localparam int WIDTH = 4;
  localparam int TAG_W = 5;
  localparam int LAT   = 2;
  localparam int ENT_W = 1 + TAG_W + WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_share_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus();

  mul_share_arbiter #(.WIDTH(WIDTH), .TAG_W(TAG_W), .LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int               checks   = 0;
  int               failures = 0;
  logic [ENT_W-1:0] exp_q[$];
  bit               m_rr     = 1'b0;
  bit               mon_on   = 1'b0;
  bit               fire0_last, fire1_last;
  bit               prev_hold = 1'b0;
  logic             prev_lane;
  logic [TAG_W-1:0] prev_tag;
  logic [WIDTH-1:0] prev_p;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [ENT_W-1:0] model(input bit lane, input int tag, input int a, input int b);
    int p;
    p = (a * b) % (1 << WIDTH);
    return {lane, tag[TAG_W-1:0], p[WIDTH-1:0]};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : mon
    bit st, can, e0, e1, f0, f1;
    logic [ENT_W-1:0] e;
    if (mon_on) begin
      st  = bus.res_valid && !bus.res_ready;
      can = !st && !bus.flush && !rst;
      e0  = can && bus.req0_valid && (!bus.req1_valid || !m_rr);
      e1  = can && bus.req1_valid && (!bus.req0_valid ||  m_rr);
      chk("req0_ready", bus.req0_ready, e0);
      chk("req1_ready", bus.req1_ready, e1);
      chk("rr", bus.rr_dbg, m_rr);
      chk("busy", bus.busy, exp_q.size() != 0);
      if (prev_hold) begin
        chk("stall_valid", bus.res_valid, 1);
        chk("stall_lane", bus.res_lane, prev_lane);
        chk("stall_tag", bus.res_tag, prev_tag);
        chk("stall_p", bus.res_p, prev_p);
      end
      f0 = bus.req0_valid && bus.req0_ready;
      f1 = bus.req1_valid && bus.req1_ready;
      if (rst || bus.flush) begin
        exp_q.delete();
      end else begin
        if (bus.res_valid && bus.res_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("res_lane", bus.res_lane, e[ENT_W-1]);
            chk("res_tag", bus.res_tag, e[WIDTH +: TAG_W]);
            chk("res_p", bus.res_p, e[WIDTH-1:0]);
          end
        end
        if (f0) exp_q.push_back(model(1'b0, bus.req0_tag, bus.req0_a, bus.req0_b));
        if (f1) exp_q.push_back(model(1'b1, bus.req1_tag, bus.req1_a, bus.req1_b));
      end
      if (rst)     m_rr = 1'b0;
      else if (f0) m_rr = 1'b1;
      else if (f1) m_rr = 1'b0;
      fire0_last = f0;
      fire1_last = f1;
      prev_hold  = st && !bus.flush && !rst;
      prev_lane  = bus.res_lane;
      prev_tag   = bus.res_tag;
      prev_p     = bus.res_p;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input bit lane, input bit v, input int a, input int b, input int tag);
    if (!lane) begin
      bus.req0_valid = v; bus.req0_a = a[WIDTH-1:0]; bus.req0_b = b[WIDTH-1:0]; bus.req0_tag = tag[TAG_W-1:0];
    end else begin
      bus.req1_valid = v; bus.req1_a = a[WIDTH-1:0]; bus.req1_b = b[WIDTH-1:0]; bus.req1_tag = tag[TAG_W-1:0];
    end
  endtask

  task automatic issue(input bit lane, input int a, input int b, input int tag);
    bit fired = 1'b0;
    set_lane(lane, 1'b1, a, b, tag);
    for (int k = 0; k < 50 && !fired; k++) begin
      @(negedge clk);
      fired = lane ? (bus.req1_valid && bus.req1_ready) : (bus.req0_valid && bus.req0_ready);
      step();
    end
    if (!fired) chk("issue_timeout", 0, 1);
    set_lane(lane, 1'b0, a, b, tag);
  endtask

  task automatic drain(input string name);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.res_ready  = 1'b1;
    for (int k = 0; k < 40 && (exp_q.size() != 0 || bus.busy); k++) step();
    chk(name, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_lane(1'b0, 1'b0, 0, 0, 0);
    set_lane(1'b1, 1'b0, 0, 0, 0);
    bus.flush     = 1'b0;
    bus.res_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_lane", bus.res_lane, 0);
    chk("rst_res_tag", bus.res_tag, 0);
    chk("rst_res_p", bus.res_p, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rr", bus.rr_dbg, 0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst    = 1'b0;
    mon_on = 1'b1;

    // Single op: latency and busy window.
    issue(1'b0, 3, 5, 7);
    for (int k = 1; k < LAT; k++) begin
      chk("lat_res_valid_early", bus.res_valid, 0);
      chk("lat_busy", bus.busy, 1);
      step();
    end
    chk("lat_res_valid", bus.res_valid, 1);
    chk("lat_res_lane", bus.res_lane, 0);
    chk("lat_res_tag", bus.res_tag, 7);
    chk("lat_res_p", bus.res_p, 15);
    chk("lat_busy_last", bus.busy, 1);
    step();
    chk("lat_busy_after", bus.busy, 0);

    // Truncation on lane 1.
    issue(1'b1, 7, 3, 1);
    issue(1'b1, 15, 15, 2);
    issue(1'b1, 0, 9, 3);
    drain("drain_overflow");

    // Continuous dual requests right after reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_lane(1'b0, 1'b1, 2, 3, 10);
    set_lane(1'b1, 1'b1, 4, 5, 20);
    for (int i = 0; i < 4; i++) begin
      bit g;
      @(negedge clk);
      chk("dual_grant0", bus.req0_ready, (i % 2) == 0);
      chk("dual_grant1", bus.req1_ready, (i % 2) == 1);
      g = bus.req1_ready;
      step();
      if (!g) set_lane(1'b0, 1'b1, i + 5, 3, 11 + i);
      else    set_lane(1'b1, 1'b1, i + 9, 7, 21 + i);
    end
    drain("drain_dual");

    // Backpressure: first result stalls the pipe for three cycles.
    set_lane(1'b0, 1'b1, 2, 3, 4);
    step();
    set_lane(1'b0, 1'b1, 4, 5, 5);
    step();
    set_lane(1'b0, 1'b1, 6, 7, 6);
    bus.res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_res_valid", bus.res_valid, 1);
      chk("bp_req0_ready", bus.req0_ready, 0);
      step();
    end
    bus.res_ready = 1'b1;
    issue(1'b0, 6, 7, 6);
    drain("drain_bp");

    // Flush kills two in-flight ops, including one being presented.
    issue(1'b0, 3, 3, 8);
    issue(1'b1, 5, 2, 9);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_res_valid", bus.res_valid, 0);
    chk("flush_busy", bus.busy, 0);
    issue(1'b0, 9, 9, 12);
    drain("drain_flush");

    // Reset with two ops in flight and rr pointing at lane 1.
    issue(1'b0, 2, 2, 13);
    issue(1'b0, 3, 2, 14);
    chk("pre_rst_rr", bus.rr_dbg, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_res_valid", bus.res_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    set_lane(1'b0, 1'b1, 1, 1, 15);
    set_lane(1'b1, 1'b1, 1, 2, 16);
    @(negedge clk);
    chk("post_rst_grant0", bus.req0_ready, 1);
    chk("post_rst_grant1", bus.req1_ready, 0);
    step();
    drain("drain_rst");

    // Random traffic with backpressure and occasional flush.
    for (int c = 0; c < 600; c++) begin
      if (bus.req0_valid && fire0_last) bus.req0_valid = 1'b0;
      if (bus.req1_valid && fire1_last) bus.req1_valid = 1'b0;
      if (!bus.req0_valid && $urandom_range(0, 99) < 60)
        set_lane(1'b0, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 31));
      if (!bus.req1_valid && $urandom_range(0, 99) < 60)
        set_lane(1'b1, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 31));
      bus.res_ready = ($urandom_range(0, 99) < 70);
      bus.flush     = ($urandom_range(0, 99) < 3);
      step();
    end
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one truncating WIDTH-bit integer multiplier between the two issue lanes of the superscalar core.
- Each lane presents operands and a destination tag over a valid/ready handshake.
- The block arbitrates round-robin and carries the product through a LAT-stage pipeline.
- It returns the product with its lane ID and tag to writeback, honouring writeback backpressure and pipeline flush.

Parameters:
- WIDTH, 4, operand and product width; product is the low WIDTH bits of A*B.
- TAG_W, 5, destination tag width (register index).
- LAT, 2, issue-to-result latency in cycles; legal range 1..4.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  lane 0 has a multiply request.
- req0_ready  out  1  lane 0 request accepted this cycle.
- req0_a  in  WIDTH  lane 0 operand A.
- req0_b  in  WIDTH  lane 0 operand B.
- req0_tag  in  TAG_W  lane 0 destination tag.
- req1_valid  in  1  lane 1 has a multiply request.
- req1_ready  out  1  lane 1 request accepted this cycle.
- req1_a  in  WIDTH  lane 1 operand A.
- req1_b  in  WIDTH  lane 1 operand B.
- req1_tag  in  TAG_W  lane 1 destination tag.
- flush  in  1  kill all in-flight operations (branch mispredict).
- res_valid  out  1  result available at output stage.
- res_ready  in  1  writeback accepts the result.
- res_lane  out  1  originating lane of the result.
- res_tag  out  TAG_W  tag of the result.
- res_p  out  WIDTH  product, low WIDTH bits of A*B.
- busy  out  1  any pipeline stage holds a valid operation.

Behaviour:
Reset:
- On clk edge with rst=1, all stage valid bits are 0 and the round-robin pointer rr is 0 (lane 0 favoured).
- res_valid, res_lane, res_tag, res_p and busy read 0.
- reqN_ready are 0 while rst is high.
- Reset mid-operation discards all in-flight work; no result is emitted for it.

Stall and acceptance:
- stall = res_valid & ~res_ready.
- While stall=1, every stage holds its contents, no request is granted and both ready outputs are 0.
- There is no bubble collapsing; a stall freezes the whole pipe.
- can_issue = ~stall & ~flush & ~rst.

Arbitration (combinational, same cycle):
- Exactly one of req0_valid/req1_valid set and can_issue: that lane's ready=1.
- Both set and can_issue: ready goes to lane rr only.
- On any grant to lane g, rr <= ~g at the clock edge; with no grant, rr holds.
- So under continuous dual requests grants alternate 0,1,0,1,...
- reqN_ready never depends on reqN_valid of the same lane being low; ready=0 whenever valid=0.
- Handshake completes on valid & ready at the edge; requesters hold operands stable until then.

Pipeline:
- Stage 1 captures {valid, lane, tag, P}.
- P = (A*B) mod 2^WIDTH, computed combinationally from the granted operands before capture. Overflow bits are dropped silently, with no flag.
- Stages 2..LAT shift forward each unstalled cycle.
- Outputs are driven directly from stage LAT registers.
- Latency: grant at edge t gives res_valid=1 in the cycle following edge t+LAT-1, i.e. LAT cycles after issue (absent stall).
- Throughput is one issue per cycle.
- A result leaves when res_valid & res_ready; in the same edge the next stage shifts in, so back-to-back results stream without a bubble.
- An unstalled stage LAT with res_valid=0 also advances.

Flush:
- flush=1 at an edge clears all stage valid bits, including a result currently presented (it is not delivered even if res_ready=1).
- No grant is made that cycle and rr holds.
- flush overrides stall.
- rst overrides flush.

busy = OR of all stage valid bits.

Test Plan:
- LAT=2, lane 0 only, a=3, b=5, tag=7, res_ready=1 -> req0_ready=1 at issue; two cycles later res_valid=1, res_lane=0, res_tag=7, res_p=15; busy high for exactly 2 cycles.
- Overflow: lane 1, a=7, b=3 -> res_p=5 (21 mod 16); a=15, b=15 -> res_p=1; a=0, b=9 -> res_p=0.
- Both lanes valid continuously for 4 cycles after reset, distinct tags -> grants 0,1,0,1; results appear in that order, one per cycle, each with matching lane/tag.
- Backpressure: issue 3 ops back-to-back, drop res_ready for 3 cycles when the first result appears -> res outputs stable during the stall, both readys 0, no op lost or duplicated; all 3 results delivered in order after res_ready returns.
- Flush: issue 2 ops, assert flush one cycle later -> no res_valid for either, busy=0 next cycle, rr unchanged; a new request the cycle after flush is granted normally.
- Reset mid-operation: 2 ops in flight with rr=1, pulse rst for one cycle -> res_valid/busy 0 afterwards, no stale result; next dual request grants lane 0 first.
